uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- Receive-side byte buffer between the UART receiver and the CPU load path.
- Accepts one byte per receiver strobe (byte-complete pulse plus 8-bit data) and holds up to DEPTH bytes in arrival order.
- Serves them to the CPU one per read operation as a zero-extended 32-bit word.
- Exposes empty/full/count and a sticky overflow flag for polling.

Parameters:
- DEPTH, 16, number of byte entries; power of two, >= 2.
- DATA_W, 8, width of one stored entry.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- DataReadFromLine  input  1  one-cycle push strobe from the receiver.
- RxByte  input  DATA_W  received byte; valid when DataReadFromLine=1.
- UARTOp  input  2  CPU operation:
  - 2'b00 none.
  - 2'b01 read/pop.
  - 2'b10 UART write (ignored here).
  - 2'b11 clear overflow.
- ReadData  output  32  registered pop result, {24'b0, byte}.
- ReadValid  output  1  1 for one cycle when ReadData was updated by a successful pop.
- Empty  output  1  count == 0.
- Full  output  1  count == DEPTH.
- Count  output  $clog2(DEPTH)+1  number of stored entries.
- Overflow  output  1  sticky; set when a push is dropped.

Behaviour:
- Reset (rst_n=0, takes effect immediately, independent of clk):
  - wr_ptr=0, rd_ptr=0, Count=0, Empty=1, Full=0, Overflow=0.
  - ReadData=32'h0000_0000, ReadValid=0.
  - Storage array is not reset.
- Reset mid-operation: all queued bytes are discarded; the first edge after release behaves as from an empty FIFO.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. Count carries the extra bit so full and empty are unambiguous.
- Push (DataReadFromLine=1):
  - Not full: mem[wr_ptr] <= RxByte, wr_ptr++.
  - Full and no pop this cycle: byte dropped, Overflow <= 1, pointers unchanged.
- Pop (UARTOp==2'b01):
  - Not empty: ReadData <= {24'b0, mem[rd_ptr]}, ReadValid <= 1, rd_ptr++.
  - Latency: data is visible on the edge after the pop cycle.
- Pop when empty:
  - ReadData <= 32'h0000_0000, ReadValid <= 0, no pointer change.
  - Not an error; no flag.
- ReadValid is 0 on every cycle without a successful pop. ReadData holds its last value otherwise.
- Simultaneous push and pop:
  - Count unchanged when both succeed.
  - When full: the pop frees a slot, so the push is accepted. No overflow.
  - When empty: the pop sees empty and returns 0; the push is stored. No bypass, so the new byte is readable by the next pop.
- Count: +1 on push only, -1 on pop only, unchanged on both or neither.
- Empty and Full are decoded from the registered Count (no extra latency).
- Overflow clear (UARTOp==2'b11):
  - Overflow <= 0.
  - If a dropped push occurs in the same cycle, set wins: Overflow stays 1.
- UARTOp 2'b10 and 2'b00 have no effect on this block.
- No state machine beyond the pointer/count registers. Control is a single registered update per cycle from the {push_ok, pop_ok} pair.

Decomposition:
- Shared package uart_pkg:
  - UARTOp encodings (UART_NOP=2'b00, UART_READ=2'b01, UART_WRITE=2'b10, UART_CLR=2'b11).
  - Default DATA_W.
  - Also used by the uart module and the CPU decode.
- One natural sub-module: uart_fifo_mem, a DEPTH x DATA_W register array.
  - Synchronous write port.
  - Asynchronous read at rd_ptr.
  - Pointer/count/flag logic stays in uart_rx_fifo.

Test Plan:
- Reset then idle -> Empty=1, Full=0, Count=0, Overflow=0, ReadData=0; pop on empty -> ReadData=0, ReadValid=0, Count stays 0.
- Push 0x41, 0x42, 0x43 on separate cycles, then three pops -> ReadData=0x41, 0x42, 0x43 each one cycle after its pop with ReadValid=1; Empty=1 afterwards.
- Push 16 bytes 0x00..0x0F -> Full=1, Count=16; push 0xAA -> dropped, Overflow=1; pop all -> 0x00..0x0F in order, 0xAA never appears.
- With Full=1, push 0x55 and pop in the same cycle -> ReadData=0x00, Count stays 16, Overflow=0; the 16th subsequent pop returns 0x55 (pointer wrap verified).
- Overflow=1, then UARTOp=2'b11 in the same cycle as a dropped push -> Overflow stays 1; UARTOp=2'b11 alone -> Overflow=0.
- Push 5 bytes, pull rst_n low between clock edges -> outputs clear immediately to reset values; after release, pop -> ReadData=0, ReadValid=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: CPU operation encodings and default widths.
// Used by the receive FIFO, the UART core and the CPU decode.
package uart_pkg;

    localparam int unsigned UART_DATA_W = 8;
    localparam int unsigned UART_WORD_W = 32;

    localparam logic [1:0] UART_NOP   = 2'b00;
    localparam logic [1:0] UART_READ  = 2'b01;
    localparam logic [1:0] UART_WRITE = 2'b10;
    localparam logic [1:0] UART_CLR   = 2'b11;

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x DATA_W register array: synchronous write, asynchronous read.
// Storage is intentionally not reset; validity is tracked by the owner.
module uart_fifo_mem #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned DATA_W = 8,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata_c
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_c = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive byte buffer between the UART receiver and the CPU load path.
// Bytes are pushed on the receiver strobe and popped by CPU read operations.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned DATA_W = UART_DATA_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     DataReadFromLine,
    input  logic [DATA_W-1:0]        RxByte,
    input  logic [1:0]               UARTOp,
    output logic [31:0]              ReadData,
    output logic                     ReadValid,
    output logic                     Empty,
    output logic                     Full,
    output logic [$clog2(DEPTH):0]   Count,
    output logic                     Overflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [DATA_W-1:0] head_c;

    logic              pop_req_c;
    logic              clr_req_c;
    logic              pop_ok_c;
    logic              push_ok_c;
    logic              drop_c;
    logic [CNT_W-1:0]  count_nxt_c;
    logic              ovf_nxt_c;

    uart_fifo_mem #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk     (clk),
        .we      (push_ok_c),
        .waddr   (wr_ptr),
        .wdata   (RxByte),
        .raddr   (rd_ptr),
        .rdata_c (head_c)
    );

    // A pop on a full FIFO frees a slot, so a same-cycle push is accepted.
    always_comb begin
        pop_req_c   = 1'b0;
        clr_req_c   = 1'b0;
        pop_ok_c    = 1'b0;
        push_ok_c   = 1'b0;
        drop_c      = 1'b0;
        count_nxt_c = Count;
        ovf_nxt_c   = Overflow;

        pop_req_c = (UARTOp == UART_READ);
        clr_req_c = (UARTOp == UART_CLR);
        pop_ok_c  = pop_req_c && !Empty;
        push_ok_c = DataReadFromLine && (!Full || pop_ok_c);
        drop_c    = DataReadFromLine && !push_ok_c;

        case ({push_ok_c, pop_ok_c})
            2'b10:   count_nxt_c = Count + CNT_W'(1);
            2'b01:   count_nxt_c = Count - CNT_W'(1);
            default: count_nxt_c = Count;
        endcase

        // Set beats clear when a drop coincides with a clear request.
        ovf_nxt_c = drop_c || (Overflow && !clr_req_c);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            Count     <= '0;
            Empty     <= 1'b1;
            Full      <= 1'b0;
            Overflow  <= 1'b0;
            ReadData  <= 32'h0000_0000;
            ReadValid <= 1'b0;
        end else begin
            if (push_ok_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok_c) begin
                rd_ptr   <= rd_ptr + PTR_W'(1);
                ReadData <= 32'(head_c);
            end else if (pop_req_c) begin
                ReadData <= 32'h0000_0000;
            end
            ReadValid <= pop_ok_c;
            Count     <= count_nxt_c;
            // Flags track the new count so they line up with Count itself.
            Empty     <= (count_nxt_c == CNT_W'(0));
            Full      <= (count_nxt_c == CNT_W'(DEPTH));
            Overflow  <= ovf_nxt_c;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: queue-based reference model compared every cycle,
// plus directed literal expectations for the main scenarios.
module tb_uart_rx_fifo;

    localparam int unsigned DEPTH  = 16;
    localparam int unsigned DATA_W = 8;

    logic              clk;
    logic              rst_n;
    logic              DataReadFromLine;
    logic [DATA_W-1:0] RxByte;
    logic [1:0]        UARTOp;
    logic [31:0]       ReadData;
    logic              ReadValid;
    logic              Empty;
    logic              Full;
    logic [4:0]        Count;
    logic              Overflow;

    int n_checks = 0;
    int n_fail   = 0;

    uart_rx_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .DataReadFromLine (DataReadFromLine),
        .RxByte           (RxByte),
        .UARTOp           (UARTOp),
        .ReadData         (ReadData),
        .ReadValid        (ReadValid),
        .Empty            (Empty),
        .Full             (Full),
        .Count            (Count),
        .Overflow         (Overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a byte queue with plain FIFO semantics.
    logic [7:0]  m_q[$];
    logic [31:0] m_rd;
    logic        m_rv;
    logic        m_ovf;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_rd  = 32'h0;
            m_rv  = 1'b0;
            m_ovf = 1'b0;
        end else begin
            m_rv = 1'b0;
            if (UARTOp == 2'b01) begin
                if (m_q.size() > 0) begin
                    m_rd = {24'h0, m_q.pop_front()};
                    m_rv = 1'b1;
                end else begin
                    m_rd = 32'h0;
                end
            end
            if (UARTOp == 2'b11) m_ovf = 1'b0;
            if (DataReadFromLine) begin
                if (m_q.size() < DEPTH) m_q.push_back(RxByte);
                else                    m_ovf = 1'b1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("m_ReadData",  ReadData,              m_rd);
        chk("m_ReadValid", 32'(ReadValid),        32'(m_rv));
        chk("m_Count",     32'(Count),            m_q.size());
        chk("m_Empty",     32'(Empty),            32'(m_q.size() == 0));
        chk("m_Full",      32'(Full),             32'(m_q.size() == DEPTH));
        chk("m_Overflow",  32'(Overflow),         32'(m_ovf));
    end

    // Drive one cycle of inputs; returns just after the edge that consumed them.
    task automatic step(input logic push, input logic [7:0] b, input logic [1:0] op);
        @(negedge clk);
        DataReadFromLine = push;
        RxByte           = b;
        UARTOp           = op;
        @(posedge clk);
        #1;
        DataReadFromLine = 1'b0;
        RxByte           = 8'h00;
        UARTOp           = 2'b00;
    endtask

    initial begin
        rst_n            = 1'b0;
        DataReadFromLine = 1'b0;
        RxByte           = 8'h00;
        UARTOp           = 2'b00;
        #12;
        chk("rst_Empty",    32'(Empty),    32'd1);
        chk("rst_Full",     32'(Full),     32'd0);
        chk("rst_Count",    32'(Count),    32'd0);
        chk("rst_Overflow", 32'(Overflow), 32'd0);
        chk("rst_ReadData", ReadData,      32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 8'h00, 2'b00);

        // Pop on empty
        step(1'b0, 8'h00, 2'b01);
        chk("empty_pop_data",  ReadData,         32'h0);
        chk("empty_pop_valid", 32'(ReadValid),   32'd0);
        chk("empty_pop_count", 32'(Count),       32'd0);

        // Three bytes in, three out
        step(1'b1, 8'h41, 2'b00);
        step(1'b1, 8'h42, 2'b00);
        step(1'b1, 8'h43, 2'b00);
        chk("three_count", 32'(Count), 32'd3);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'h00, 2'b01);
            chk("three_data",  ReadData,       32'h41 + 32'(i));
            chk("three_valid", 32'(ReadValid), 32'd1);
        end
        step(1'b0, 8'h00, 2'b00);
        chk("three_valid_idle", 32'(ReadValid), 32'd0);
        chk("three_data_hold",  ReadData,       32'h43);
        chk("three_empty",      32'(Empty),     32'd1);

        // Fill to full, then overflow
        for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 2'b00);
        chk("fill_full",  32'(Full),     32'd1);
        chk("fill_count", 32'(Count),    32'd16);
        chk("fill_ovf",   32'(Overflow), 32'd0);
        step(1'b1, 8'hAA, 2'b00);
        chk("drop_ovf",   32'(Overflow), 32'd1);
        chk("drop_count", 32'(Count),    32'd16);

        // Clear coinciding with a drop: set wins
        step(1'b1, 8'hBB, 2'b11);
        chk("clr_drop_ovf", 32'(Overflow), 32'd1);
        step(1'b0, 8'h00, 2'b11);
        chk("clr_ovf", 32'(Overflow), 32'd0);

        // Push and pop together while full
        step(1'b1, 8'h55, 2'b01);
        chk("full_pp_data",  ReadData,       32'h00);
        chk("full_pp_valid", 32'(ReadValid), 32'd1);
        chk("full_pp_count", 32'(Count),     32'd16);
        chk("full_pp_ovf",   32'(Overflow),  32'd0);
        for (int i = 1; i < 16; i++) begin
            step(1'b0, 8'h00, 2'b01);
            chk("drain_data", ReadData, 32'(i));
        end
        step(1'b0, 8'h00, 2'b01);
        chk("wrap_data",  ReadData,   32'h55);
        chk("wrap_empty", 32'(Empty), 32'd1);

        // Push and pop together while empty: no bypass
        step(1'b1, 8'h66, 2'b01);
        chk("empty_pp_data",  ReadData,       32'h0);
        chk("empty_pp_valid", 32'(ReadValid), 32'd0);
        chk("empty_pp_count", 32'(Count),     32'd1);
        step(1'b0, 8'h00, 2'b01);
        chk("empty_pp_next", ReadData, 32'h66);

        // Asynchronous reset mid-operation
        for (int i = 0; i < 5; i++) step(1'b1, 8'h70 + 8'(i), 2'b00);
        step(1'b0, 8'h00, 2'b01);
        chk("pre_rst_data", ReadData, 32'h70);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_count", 32'(Count),     32'd0);
        chk("arst_empty", 32'(Empty),     32'd1);
        chk("arst_data",  ReadData,       32'h0);
        chk("arst_valid", 32'(ReadValid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 8'h00, 2'b01);
        chk("post_rst_data",  ReadData,       32'h0);
        chk("post_rst_valid", 32'(ReadValid), 32'd0);
        chk("post_rst_count", 32'(Count),     32'd0);

        step(1'b0, 8'h00, 2'b10);
        chk("write_op_count", 32'(Count), 32'd0);
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
